irq_ctl: RTL and testbench

//  Interrupt request generator feeding the irq input of the instruction control decoder.

---
 rtl/irq_ctl_pkg.sv | 16 +
 rtl/irq_ctl_if.sv | 28 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_ctl.sv | 111 +++++++++++
 tb/tb_irq_ctl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/irq_ctl_pkg.sv
// Shared types and helpers for the interrupt request controller.
package irq_ctl_pkg;

  // Request FSM states; encodings kept from the original 2-bit state codes.
  typedef enum logic [1:0] {
    IRQS_IDLE    = 2'd0,
    IRQS_REQ     = 2'd1,
    IRQS_SERVICE = 2'd2
  } irq_state_e;

  // Width of an interrupt index: max(1, clog2(n)).
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_ctl_if.sv
// Interrupt controller signal bundle: peripheral lines, CPU status/ack, mask port, request.
interface irq_ctl_if #(
  parameter int unsigned N_IRQ = 8
);
  localparam int unsigned ID_W = irq_ctl_pkg::id_width(N_IRQ);

  logic [N_IRQ-1:0] irq_src;
  logic             pc_super;
  logic             irq_ack;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] pending;
  logic             irq;
  logic [ID_W-1:0]  irq_id;

  // Driver side: peripherals, datapath and mask writer.
  modport master (
    output irq_src, pc_super, irq_ack, mask_we, mask_wdata,
    input  mask, pending, irq, irq_id
  );

  // Controller side.
  modport slave (
    input  irq_src, pc_super, irq_ack, mask_we, mask_wdata,
    output mask, pending, irq, irq_id
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module irq_prio_enc #(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic [N_IRQ-1:0] req,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  // Scan upward and keep only the first hit so index 0 has the highest priority.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (req[i] && !any) begin
        any = 1'b1;
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt request generator: edge-detects lines, holds them pending under a mask,
// and presents one request at a time to the instruction control decoder.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int unsigned      N_IRQ    = 8,
  parameter logic [N_IRQ-1:0] MASK_RST = '0
) (
  input  logic      clk,
  input  logic      reset_n,
  irq_ctl_if.slave  bus
);

  localparam int unsigned ID_W = id_width(N_IRQ);

  logic [N_IRQ-1:0] src_q;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] pend_q;
  irq_state_e       state_q;
  logic             irq_q;
  logic [ID_W-1:0]  id_q;

  logic [N_IRQ-1:0] evt;
  logic [N_IRQ-1:0] sel;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] cand;
  logic             ack_in_req;
  logic             cur_en;
  logic             cand_any;
  logic [ID_W-1:0]  cand_idx;

  // Rising-edge events, one-hot of the latched id, and the clear applied on a taken request.
  always_comb begin
    evt        = bus.irq_src & ~src_q;
    ack_in_req = (state_q == IRQS_REQ) && bus.irq_ack;
    sel        = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      sel[i] = (id_q == ID_W'(i));
    end
    clr    = ack_in_req ? sel : '0;
    cand   = pend_q & mask_q;
    cur_en = |(cand & sel);
  end

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_enc (
    .req (cand),
    .any (cand_any),
    .idx (cand_idx)
  );

  // Input history, enable mask and pending latch; a same-cycle event beats the ack clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q  <= '0;
      mask_q <= MASK_RST;
      pend_q <= '0;
    end else begin
      src_q  <= bus.irq_src;
      pend_q <= (pend_q & ~clr) | evt;
      if (bus.mask_we) begin
        mask_q <= bus.mask_wdata;
      end
    end
  end

  // Request FSM with registered irq/irq_id; the id is frozen for the whole request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IRQS_IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IRQS_IDLE: begin
          if (cand_any && !bus.pc_super) begin
            state_q <= IRQS_REQ;
            irq_q   <= 1'b1;
            id_q    <= cand_idx;
          end
        end
        IRQS_REQ: begin
          if (bus.irq_ack) begin
            state_q <= IRQS_SERVICE;
            irq_q   <= 1'b0;
          end else if (bus.pc_super || !cur_en) begin
            state_q <= IRQS_IDLE;
            irq_q   <= 1'b0;
          end
        end
        IRQS_SERVICE: begin
          if (!bus.pc_super) begin
            state_q <= IRQS_IDLE;
          end
        end
        default: begin
          state_q <= IRQS_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mask    = mask_q;
  assign bus.pending = pend_q;
  assign bus.irq     = irq_q;
  assign bus.irq_id  = id_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Self-checking bench for irq_ctl: table of per-cycle vectors plus corner-case sequences.
module tb_irq_ctl;

  logic clk;
  logic reset_n;

  irq_ctl_if #(.N_IRQ(8)) bus ();

  irq_ctl #(
    .N_IRQ    (8),
    .MASK_RST (8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic [7:0] src;
    logic       sup;
    logic       ack;
    logic       e_irq;
    logic [2:0] e_id;
    logic [7:0] e_pend;
    logic [7:0] e_mask;
  } vec_t;

  typedef struct {
    logic       irq;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] mask;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic [7:0] src,
                              input logic sup, input logic ack, input logic ei,
                              input logic [2:0] eid, input logic [7:0] ep, input logic [7:0] em);
    vec_t v;
    v.we = we; v.wd = wd; v.src = src; v.sup = sup; v.ack = ack;
    v.e_irq = ei; v.e_id = eid; v.e_pend = ep; v.e_mask = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue its expected outputs, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    bus.mask_we    = v.we;
    bus.mask_wdata = v.wd;
    bus.irq_src    = v.src;
    bus.pc_super   = v.sup;
    bus.irq_ack    = v.ack;
    sb.push_back('{v.e_irq, v.e_id, v.e_pend, v.e_mask, tag});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_irq"},     32'(bus.irq),     32'(e.irq));
      chk({e.tag, "_irq_id"},  32'(bus.irq_id),  32'(e.id));
      chk({e.tag, "_pending"}, 32'(bus.pending), 32'(e.pend));
      chk({e.tag, "_mask"},    32'(bus.mask),    32'(e.mask));
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.irq_src    = '0;
    bus.pc_super   = 1'b0;
    bus.irq_ack    = 1'b0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;

    //          we wd     src    sup ack  irq id  pend   mask
    // enable all, single event on line 3, ack, supervisor hold in SERVICE
    tbl.push_back(mk(1, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h08, 0, 0, 0, 0, 8'h08, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h08, 0, 0, 1, 3, 8'h08, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h08, 0, 0, 1, 3, 8'h08, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 3, 8'h00, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 1, 0, 3, 8'h00, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 3, 8'h00, 8'hFF));
    // lines 6 and 2 together: 2 first, then 6
    tbl.push_back(mk(0, 8'h00, 8'h44, 0, 0, 0, 3, 8'h44, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 2, 8'h44, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 2, 8'h40, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 2, 8'h40, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 2, 8'h40, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 6, 8'h40, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 6, 8'h00, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 6, 8'h00, 8'hFF));
    // supervisor blocking, drop out of REQ, ack beating pc_super
    tbl.push_back(mk(0, 8'h00, 8'h02, 1, 0, 0, 6, 8'h02, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h02, 1, 0, 0, 6, 8'h02, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 6, 8'h02, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h02, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h02, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h02, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 1, 0, 1, 8'h00, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 8'hFF));
    // masked event, late enable, mask removed during REQ
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h10, 0, 0, 0, 1, 8'h10, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h10, 0, 0, 0, 1, 8'h10, 8'h00));
    tbl.push_back(mk(1, 8'h10, 8'h00, 0, 0, 0, 1, 8'h10, 8'h10));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 4, 8'h10, 8'h10));
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 0, 1, 4, 8'h10, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 4, 8'h10, 8'h00));
    tbl.push_back(mk(1, 8'hFF, 8'h00, 0, 0, 0, 4, 8'h10, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 4, 8'h10, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 4, 8'h00, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 4, 8'h00, 8'hFF));
    // higher-priority line arriving during REQ must not preempt
    tbl.push_back(mk(0, 8'h00, 8'h08, 0, 0, 0, 4, 8'h08, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h08, 0, 0, 1, 3, 8'h08, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h09, 0, 0, 1, 3, 8'h09, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h09, 0, 0, 1, 3, 8'h09, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 3, 8'h01, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 3, 8'h01, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h01, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 8'hFF));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF));

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_irq",     32'(bus.irq),     32'd0);
    chk("rst_irq_id",  32'(bus.irq_id),  32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_mask",    32'(bus.mask),    32'h00);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("tbl%0d", i));
    end

    // Line 5 held high for 20 cycles: one event, one request
    for (int i = 0; i < 20; i++) begin
      if (i == 0)
        step(mk(0, 8'h00, 8'h20, 0, 0, 0, 0, 8'h20, 8'hFF), $sformatf("hold%0d", i));
      else if (i == 1)
        step(mk(0, 8'h00, 8'h20, 0, 0, 1, 5, 8'h20, 8'hFF), $sformatf("hold%0d", i));
      else
        step(mk(0, 8'h00, 8'h20, 0, (i == 2), 0, 5, 8'h00, 8'hFF), $sformatf("hold%0d", i));
    end
    step(mk(0, 8'h00, 8'h00, 0, 0, 0, 5, 8'h00, 8'hFF), "hold_end");

    // New event on line 0 in the same cycle as its ack: set wins
    step(mk(0, 8'h00, 8'h01, 0, 0, 0, 5, 8'h01, 8'hFF), "race_a");
    step(mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h01, 8'hFF), "race_b");
    step(mk(0, 8'h00, 8'h01, 0, 1, 0, 0, 8'h01, 8'hFF), "race_c");
    step(mk(0, 8'h00, 8'h01, 0, 0, 0, 0, 8'h01, 8'hFF), "race_d");
    step(mk(0, 8'h00, 8'h01, 0, 0, 1, 0, 8'h01, 8'hFF), "race_e");

    // Asynchronous reset in the middle of REQ
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_irq",     32'(bus.irq),     32'd0);
    chk("arst_irq_id",  32'(bus.irq_id),  32'd0);
    chk("arst_pending", 32'(bus.pending), 32'd0);
    chk("arst_mask",    32'(bus.mask),    32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    step(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
